ysyx_22050133_mem_arb: RTL and testbench
========================================

// Module: ysyx_22050133_mem_arb
// PURPOSE
//  Arbiter for the single shared memory port between the IFU (instruction fetch, read-only) and the LSU (data load/store).
//  Keeps one outstanding transaction; latches the winner's request, drives the downstream port, routes the response back.
//  Sits between IFU/LSU and the memory model/bus; replaces direct per-stage vmem access.
// PARAMETERS
//  ADDR_W   64   address width
//  DATA_W   64   data width; wmask width is DATA_W/8
//  TMO_CYC  255  max cycles in WAIT before forced error completion; counter width $clog2(TMO_CYC+1)
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         asynchronous active-low reset
//  if_req     in   1         IFU read request, held until if_gnt
//  if_addr    in   ADDR_W    IFU fetch address
//  if_gnt     out  1         1-cycle pulse: IFU request accepted
//  if_rvalid  out  1         1-cycle pulse: IFU response valid
//  if_rdata   out  DATA_W    IFU read data (valid with if_rvalid)
//  ls_req     in   1         LSU request, held until ls_gnt
//  ls_we      in   1         1 = store, 0 = load
//  ls_addr    in   ADDR_W    LSU address
//  ls_wdata   in   DATA_W    store data
//  ls_wmask   in   DATA_W/8  store byte mask
//  ls_gnt     out  1         1-cycle pulse: LSU request accepted
//  ls_rvalid  out  1         1-cycle pulse: load data / store ack
//  ls_rdata   out  DATA_W    load data (0 for store ack)
//  m_req      out  1         downstream request, held until m_gnt
//  m_we       out  1         downstream write enable
//  m_addr     out  ADDR_W    downstream address
//  m_wdata    out  DATA_W    downstream write data
//  m_wmask    out  DATA_W/8  downstream byte mask (0 on reads)
//  m_gnt      in   1         downstream accepts m_req this cycle
//  m_rvalid   in   1         downstream response (read data or write ack)
//  m_rdata    in   DATA_W    downstream read data
//  err        out  1         1-cycle pulse: timeout completion, coincident with owner's rvalid
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, owner none, all outputs 0, timeout counter 0, RR pointer = IF-last.
//  FSM IDLE -> REQ -> WAIT -> IDLE.
//  IDLE: if any req, pick winner combinationally, pulse its gnt same cycle, latch we/addr/wdata/wmask (if: we=0, wmask=0), ->REQ.
//  REQ: m_req=1 with latched fields, stable until m_gnt; on m_gnt ->WAIT, timeout counter cleared.
//  WAIT: m_req=0; on m_rvalid, owner's rvalid=1 and rdata=m_rdata (combinational, same cycle), ->IDLE.
//  Timeout: counter increments each WAIT cycle; when it reaches TMO_CYC without m_rvalid -> owner rvalid=1, rdata=0, err=1, ->IDLE.
//  Min latency: req@0 gnt@0, m_req@1, m_gnt@1, m_rvalid@2 -> x_rvalid@2; next accept earliest cycle 3.
//  m_rvalid in IDLE/REQ ignored (stale response after reset/abort); no rvalid emitted.
//  Non-owner rvalid always 0; non-winner gnt 0; at most one gnt per cycle.
//  Requester changing fields after gnt has no effect; fields are latched.
//  Reset mid-transaction aborts immediately; no response delivered to the pending owner.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; on simultaneous if_req & ls_req, the requester not granted last wins;
//    pointer updates on every gnt.
//  MEM_ARB_RR_EN undefined: fixed priority, LSU always beats IFU; pointer logic absent.
// STRUCTURE
//  Shared define header: FSM state encodings (IDLE/REQ/WAIT), owner IDs (OWN_NONE/OWN_IF/OWN_LS),
//    default width constants.
//  Sub-module ysyx_22050133_arb_pick: 2-way picker (req vector, last-grant ptr -> one-hot grant),
//    fixed/RR selected by MEM_ARB_RR_EN.
// TESTING
//  if_req only, addr=0x80000000, m_gnt@REQ, m_rvalid next cycle rdata=0x00000413 -> if_gnt@0, if_rvalid@2 rdata=0x00000413.
//  ls store we=1 addr=0x80001004 wdata=0xDEADBEEF wmask=0x0F, m_gnt delayed 3 cycles -> m_req/fields stable 3 cycles;
//    ls_rvalid on ack, ls_rdata=0.
//  if_req & ls_req same cycle, repeated 4 times -> fixed: LS,LS,LS,LS;
//    RR: LS,IF,LS,IF (reset ptr IF-last).
//  m_gnt given, m_rvalid never, TMO_CYC=255 -> after 255 WAIT cycles ls_rvalid=1, err=1, rdata=0; FSM in IDLE next cycle.
//  Assert rst=0 in WAIT, release, then pulse m_rvalid -> no rvalid/err emitted, all outputs 0, next if_req serviced normally.
//  Back-to-back IFU requests with 0-wait memory -> gnt on cycles 0,3,6; never two outstanding m_req.

Source files
------------

// File: rtl/ysyx_22050133_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter:
// FSM state encodings, owner IDs, grant-vector bit positions and default widths.
package ysyx_22050133_mem_arb_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int DATA_W_DEF  = 64;
  localparam int TMO_CYC_DEF = 255;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Owner of the outstanding transaction
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  // Bit positions in the request / grant vectors
  localparam int REQ_IF = 0;
  localparam int REQ_LS = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_LS   = 2'b10;

  // Map a one-hot grant vector to the owner ID of the transaction it starts
  function automatic logic [1:0] owner_of(input logic [1:0] gnt);
    logic [1:0] own;
    case (gnt)
      GNT_IF:  own = OWN_IF;
      GNT_LS:  own = OWN_LS;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/ysyx_22050133_arb_pick.sv
// 2-way requester picker: request vector (+ last-grant pointer) -> one-hot grant.
// Build option MEM_ARB_RR_EN: round-robin on ties (the requester not granted
// last wins); without it LSU has fixed priority and the pointer port is absent.
module ysyx_22050133_arb_pick
  import ysyx_22050133_mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       i_last_ls,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Pick at most one winner from the current request vector
  always_comb begin
    o_gnt = GNT_NONE;
    case (i_req)
      GNT_IF:  o_gnt = GNT_IF;
      GNT_LS:  o_gnt = GNT_LS;
      2'b11: begin
`ifdef MEM_ARB_RR_EN
        if (i_last_ls) begin
          o_gnt = GNT_IF;
        end else begin
          o_gnt = GNT_LS;
        end
`else
        o_gnt = GNT_LS;
`endif
      end
      default: o_gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ysyx_22050133_mem_arb.sv
// Single-outstanding arbiter for the shared memory port between IFU and LSU.
// Latches the winner's request, drives it downstream until accepted, then
// routes the response (or a timeout error completion) back to the owner.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of LSU priority.
// rst is asynchronous and active-low.
module ysyx_22050133_mem_arb
  import ysyx_22050133_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  localparam int               MASK_W  = DATA_W / 8;
  localparam int               CNT_W   = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0] w_req;
  logic [1:0] w_pick;
  logic       w_in_idle;
  logic       w_in_req;
  logic       w_in_wait;
  logic       w_resp;
  logic       w_tmo;
  logic       w_done;
  logic       w_accept;

  assign w_req     = {ls_req, if_req};
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_accept  = w_in_idle & (|w_pick);
  // A real response in the same cycle as the limit wins over the timeout
  assign w_resp    = w_in_wait & m_rvalid;
  assign w_tmo     = w_in_wait & ~m_rvalid & (r_cnt == TMO_LIM);
  assign w_done    = w_resp | w_tmo;

`ifdef MEM_ARB_RR_EN
  logic r_last_ls;

  // Remember which requester was granted last; reset value means IFU-last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ls <= 1'b0;
    end else if (w_accept) begin
      r_last_ls <= w_pick[REQ_LS];
    end
  end
`endif

  ysyx_22050133_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .i_last_ls (r_last_ls),
`endif
    .i_req     (w_req),
    .o_gnt     (w_pick)
  );

  // Transaction FSM: latch winner in IDLE, hold request in REQ, await response in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_wmask <= {MASK_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_REQ;
            r_owner <= owner_of(w_pick);
            if (w_pick[REQ_LS]) begin
              r_we    <= ls_we;
              r_addr  <= ls_addr;
              r_wdata <= ls_wdata;
              // Byte mask only meaningful for stores
              r_wmask <= ls_we ? ls_wmask : {MASK_W{1'b0}};
            end else begin
              r_we    <= 1'b0;
              r_addr  <= if_addr;
              r_wdata <= {DATA_W{1'b0}};
              r_wmask <= {MASK_W{1'b0}};
            end
          end
        end
        ST_REQ: begin
          if (m_gnt) begin
            r_state <= ST_WAIT;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Grants, downstream drive and response routing
  always_comb begin
    if_gnt    = w_accept & w_pick[REQ_IF];
    ls_gnt    = w_accept & w_pick[REQ_LS];
    m_req     = w_in_req;
    m_we      = w_in_req & r_we;
    if_rvalid = w_done & (r_owner == OWN_IF);
    ls_rvalid = w_done & (r_owner == OWN_LS);
    err       = w_tmo;
    if (w_in_req) begin
      m_addr  = r_addr;
      m_wdata = r_wdata;
      m_wmask = r_wmask;
    end else begin
      m_addr  = {ADDR_W{1'b0}};
      m_wdata = {DATA_W{1'b0}};
      m_wmask = {MASK_W{1'b0}};
    end
    if (w_resp && (r_owner == OWN_IF)) begin
      if_rdata = m_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    // Store acks return zero data
    if (w_resp && (r_owner == OWN_LS) && !r_we) begin
      ls_rdata = m_rdata;
    end else begin
      ls_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_mem_arb.sv
// Directed bench for ysyx_22050133_mem_arb: table-driven single transactions
// plus hand-written multi-cycle sequences (stalled grant, timeout, reset abort,
// simultaneous requests, back-to-back fetches).
module tb_ysyx_22050133_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req, ls_we;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_gnt, ls_rvalid;
  logic [63:0] ls_rdata;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic        m_gnt, m_rvalid;
  logic [63:0] m_rdata;
  logic        err;

  logic        m_gnt_d, m_rvalid_d, mem_auto, r_pend;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Zero-wait memory model when mem_auto is set, otherwise hand-driven
  assign m_gnt    = mem_auto ? m_req  : m_gnt_d;
  assign m_rvalid = mem_auto ? r_pend : m_rvalid_d;

  always @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= 1'b0;
    else      r_pend <= mem_auto & m_req & m_gnt;
  end

  ysyx_22050133_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .err(err)
  );

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] mrdata;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One transaction with immediate m_gnt and response on the next cycle
  task automatic run_vec(input vec_t v, input int idx);
    if_req   = !v.is_ls;
    if_addr  = v.addr;
    ls_req   = v.is_ls;
    ls_we    = v.we;
    ls_addr  = v.addr;
    ls_wdata = v.wdata;
    ls_wmask = v.wmask;
    samp();
    chk($sformatf("v%0d_if_gnt", idx), {63'd0, if_gnt}, {63'd0, !v.is_ls});
    chk($sformatf("v%0d_ls_gnt", idx), {63'd0, ls_gnt}, {63'd0, v.is_ls});
    chk($sformatf("v%0d_mreq_idle", idx), {63'd0, m_req}, 64'd0);
    step();
    if_req   = 1'b0;
    ls_req   = 1'b0;
    if_addr  = ~v.addr;
    ls_addr  = ~v.addr;
    ls_wdata = ~v.wdata;
    ls_wmask = ~v.wmask;
    ls_we    = ~v.we;
    m_gnt_d  = 1'b1;
    samp();
    chk($sformatf("v%0d_m_req", idx), {63'd0, m_req}, 64'd1);
    chk($sformatf("v%0d_m_we", idx), {63'd0, m_we}, {63'd0, v.is_ls & v.we});
    chk($sformatf("v%0d_m_addr", idx), m_addr, v.addr);
    chk($sformatf("v%0d_m_wmask", idx), {56'd0, m_wmask}, {56'd0, v.exp_wmask});
    if (v.is_ls && v.we) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.wdata);
    step();
    m_gnt_d    = 1'b0;
    m_rvalid_d = 1'b1;
    m_rdata    = v.mrdata;
    samp();
    chk($sformatf("v%0d_m_req_wait", idx), {63'd0, m_req}, 64'd0);
    chk($sformatf("v%0d_if_rvalid", idx), {63'd0, if_rvalid}, {63'd0, !v.is_ls});
    chk($sformatf("v%0d_ls_rvalid", idx), {63'd0, ls_rvalid}, {63'd0, v.is_ls});
    chk($sformatf("v%0d_rdata", idx), v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), {63'd0, err}, 64'd0);
    step();
    m_rvalid_d = 1'b0;
  endtask

  initial begin
    logic exp_ls;
    int   early;

    rst = 1'b0; if_req = 1'b0; if_addr = 64'd0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = 64'd0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    m_gnt_d = 1'b0; m_rvalid_d = 1'b0; m_rdata = 64'd0; mem_auto = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0413, 8'h00, 64'h0000_0413};
    vecs[1] = '{1'b1, 1'b0, 64'h8000_1000, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 8'h00, 64'h1122_3344_5566_7788};
    vecs[2] = '{1'b1, 1'b1, 64'h8000_1008, 64'hCAFE_F00D_1234_5678, 8'hF0, 64'h0000_FFFF, 8'hF0, 64'd0};
    vecs[3] = '{1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset state, with a stale response arriving during reset
    m_rvalid_d = 1'b1;
    samp();
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_gnts", {62'd0, if_gnt, ls_gnt}, 64'd0);
    chk("rst_rvalids", {61'd0, if_rvalid, ls_rvalid, err}, 64'd0);
    step();
    step();
    rst = 1'b1;
    samp();
    chk("stale_idle_rvalids", {61'd0, if_rvalid, ls_rvalid, err}, 64'd0);
    step();
    m_rvalid_d = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Store with m_gnt held off for three cycles
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1004;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    samp();
    chk("st_ls_gnt", {63'd0, ls_gnt}, 64'd1);
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'd0; ls_wdata = 64'd0; ls_wmask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk($sformatf("st_hold%0d_m_req", i), {63'd0, m_req}, 64'd1);
      chk($sformatf("st_hold%0d_m_we", i), {63'd0, m_we}, 64'd1);
      chk($sformatf("st_hold%0d_m_addr", i), m_addr, 64'h8000_1004);
      chk($sformatf("st_hold%0d_m_wdata", i), m_wdata, 64'hDEAD_BEEF);
      chk($sformatf("st_hold%0d_m_wmask", i), {56'd0, m_wmask}, 64'h0F);
      step();
    end
    m_gnt_d = 1'b1;
    samp();
    chk("st_gnt_m_req", {63'd0, m_req}, 64'd1);
    step();
    m_gnt_d = 1'b0; m_rvalid_d = 1'b1; m_rdata = 64'h1234;
    samp();
    chk("st_ack_rvalid", {62'd0, ls_rvalid, if_rvalid}, 64'b10);
    chk("st_ack_rdata", ls_rdata, 64'd0);
    chk("st_ack_err", {63'd0, err}, 64'd0);
    step();
    m_rvalid_d = 1'b0;

    // Timeout: granted load, response never arrives
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_2000;
    samp();
    chk("tmo_ls_gnt", {63'd0, ls_gnt}, 64'd1);
    step();
    ls_req = 1'b0; m_gnt_d = 1'b1;
    samp();
    step();
    m_gnt_d = 1'b0; m_rdata = 64'hBAD;
    early = 0;
    for (int i = 1; i <= 255; i++) begin
      samp();
      early += int'(ls_rvalid | if_rvalid | err);
      step();
    end
    chk("tmo_early_completions", 64'(early), 64'd0);
    samp();
    chk("tmo_ls_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("tmo_err", {63'd0, err}, 64'd1);
    chk("tmo_rdata", ls_rdata, 64'd0);
    chk("tmo_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    step();
    m_rvalid_d = 1'b1; if_req = 1'b1; if_addr = 64'h8000_0040;
    samp();
    chk("tmo_idle_if_gnt", {63'd0, if_gnt}, 64'd1);
    chk("tmo_idle_stale", {62'd0, ls_rvalid, err}, 64'd0);
    step();
    if_req = 1'b0; m_rvalid_d = 1'b0; m_gnt_d = 1'b1;
    samp();
    chk("tmo_next_m_addr", m_addr, 64'h8000_0040);
    step();
    m_gnt_d = 1'b0; m_rvalid_d = 1'b1; m_rdata = 64'h77;
    samp();
    chk("tmo_next_rdata", {if_rdata[62:0], if_rvalid}, {63'h77, 1'b1});
    step();
    m_rvalid_d = 1'b0;

    // Reset asserted while waiting for a response
    if_req = 1'b1; if_addr = 64'h8000_0100;
    samp();
    chk("abort_if_gnt", {63'd0, if_gnt}, 64'd1);
    step();
    if_req = 1'b0; m_gnt_d = 1'b1;
    samp();
    step();
    m_gnt_d = 1'b0;
    samp();
    rst = 1'b0;
    #1;
    chk("abort_in_rst_outs", {59'd0, m_req, if_gnt, if_rvalid, ls_rvalid, err}, 64'd0);
    step();
    rst = 1'b1; m_rvalid_d = 1'b1; m_rdata = 64'h55;
    samp();
    chk("abort_stale_rvalid", {61'd0, if_rvalid, ls_rvalid, err}, 64'd0);
    chk("abort_stale_rdata", if_rdata, 64'd0);
    chk("abort_m_req", {63'd0, m_req}, 64'd0);
    step();
    m_rvalid_d = 1'b0;
    run_vec(vecs[0], 10);

    // Simultaneous requests, four rounds from a fresh reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_ls = (k % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      if_req = 1'b1; if_addr = 64'h8000_0200;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_3000;
      samp();
      chk($sformatf("tie%0d_gnt", k), {62'd0, ls_gnt, if_gnt}, {62'd0, exp_ls, !exp_ls});
      step();
      if_req = 1'b0; ls_req = 1'b0; m_gnt_d = 1'b1;
      samp();
      chk($sformatf("tie%0d_m_addr", k), m_addr, exp_ls ? 64'h8000_3000 : 64'h8000_0200);
      step();
      m_gnt_d = 1'b0; m_rvalid_d = 1'b1; m_rdata = 64'(k + 1);
      samp();
      chk($sformatf("tie%0d_rvalid", k), {62'd0, ls_rvalid, if_rvalid}, {62'd0, exp_ls, !exp_ls});
      step();
      m_rvalid_d = 1'b0;
    end

    // Back-to-back fetches against a zero-wait memory
    mem_auto = 1'b1; m_rdata = 64'h13;
    if_req = 1'b1; if_addr = 64'h8000_0000;
    for (int c = 0; c < 9; c++) begin
      samp();
      chk($sformatf("b2b%0d_if_gnt", c), {63'd0, if_gnt}, {63'd0, c % 3 == 0});
      chk($sformatf("b2b%0d_m_req", c), {63'd0, m_req}, {63'd0, c % 3 == 1});
      chk($sformatf("b2b%0d_if_rvalid", c), {63'd0, if_rvalid}, {63'd0, c % 3 == 2});
      if (c % 3 == 2) chk($sformatf("b2b%0d_if_rdata", c), if_rdata, 64'h13);
      step();
    end
    if_req = 1'b0;
    mem_auto = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
